// File: rtl/reg_bus_initiator.sv
// reg_bus_initiator: command-driven initiator for the simple register bus.
// Accepts WRITE / READ / RMW commands on a valid/ready port, sequences the
// bus_wen / bus_ren strobes, captures read data one cycle after bus_ren and
// returns exactly one response per accepted command.
// Optional build macro: REGBUS_RMW_EN enables the read-modify-write op; when
// it is undefined, op 2'b10 completes as an error response with no bus access.
module reg_bus_initiator #(
  parameter int unsigned ADDRWIDTH = 4,
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned NUM_REGS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0] cmd_wdata,
  input  logic [DATAWIDTH-1:0] cmd_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDRWIDTH-1:0] bus_addr,
  output logic                 bus_wen,
  output logic [DATAWIDTH-1:0] bus_wr_data,
  output logic                 bus_ren,
  input  logic [DATAWIDTH-1:0] bus_rd_data
);

  localparam logic [1:0] OP_WRITE = 2'b00;
`ifdef REGBUS_RMW_EN
  localparam logic [1:0] OP_RMW   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
`ifdef REGBUS_RMW_EN
    RMW_WR,
`endif
    RESP
  } state_t;

  state_t state;

  logic op_bad;
  logic addr_bad;
  logic cmd_bad;

`ifdef REGBUS_RMW_EN
  logic                 is_rmw;
  logic [DATAWIDTH-1:0] wdata_q;
  logic [DATAWIDTH-1:0] mask_q;
  logic [DATAWIDTH-1:0] rmw_merge;

  // Only the reserved encoding is illegal when RMW is built in
  assign op_bad = (cmd_op == OP_RSVD);

  // Bitwise merge: masked bits take the new value, the rest keep the read value
  assign rmw_merge = (bus_rd_data & ~mask_q) | (wdata_q & mask_q);
`else
  logic unused_mask;

  // Without RMW support both 2'b10 and 2'b11 are rejected
  assign op_bad = cmd_op[1];

  // The mask has no consumer in this build
  assign unused_mask = ^cmd_mask;
`endif

  // Addresses at or beyond the implemented register count are rejected
  assign addr_bad = (32'(cmd_addr) >= 32'(NUM_REGS));
  assign cmd_bad  = op_bad | addr_bad;

  // Command sequencer: state, bus strobes and response, all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      bus_addr    <= '0;
      bus_wen     <= 1'b0;
      bus_wr_data <= '0;
      bus_ren     <= 1'b0;
`ifdef REGBUS_RMW_EN
      is_rmw      <= 1'b0;
      wdata_q     <= '0;
      mask_q      <= '0;
`endif
    end else begin
      // Strobes are single-cycle pulses unless a state re-asserts them
      bus_wen <= 1'b0;
      bus_ren <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_bad) begin
              // Rejected command: respond next cycle without touching the bus
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              bus_addr <= cmd_addr;
`ifdef REGBUS_RMW_EN
              is_rmw   <= (cmd_op == OP_RMW);
              wdata_q  <= cmd_wdata;
              mask_q   <= cmd_mask;
`endif
              if (cmd_op == OP_WRITE) begin
                state       <= WR;
                bus_wen     <= 1'b1;
                bus_wr_data <= cmd_wdata;
              end else begin
                state   <= RD;
                bus_ren <= 1'b1;
              end
            end
          end
        end

        WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end

        RD: begin
          // Responder registers the read data during this cycle
          state <= CAP;
        end

        CAP: begin
          // Read data is valid now; rsp_rdata doubles as the capture register
          rsp_rdata <= bus_rd_data;
          rsp_err   <= 1'b0;
`ifdef REGBUS_RMW_EN
          if (is_rmw) begin
            state       <= RMW_WR;
            bus_wen     <= 1'b1;
            bus_wr_data <= rmw_merge;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
`else
          state     <= RESP;
          rsp_valid <= 1'b1;
`endif
        end

`ifdef REGBUS_RMW_EN
        RMW_WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
`endif

        RESP: begin
          // Hold the response until the consumer takes it
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
